// File: rtl/wave_cfg_sched.sv
// Stages func/amp/freq button selections and commits them at a period boundary (or timeout); optional auto func sweep.
// Commit lands one cycle after the qualifying period_end/timeout; there is no backpressure, so every pulse is consumed.
module wave_cfg_sched #(
  parameter int NUM_FUNC     = 5,
  parameter int AUTO_PERIODS = 16,
  parameter int TIMEOUT      = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_pulse,
  input  logic       period_end,
  output logic [2:0] func_sel,
  output logic [2:0] amp_sel,
  output logic [2:0] freq_sel,
  output logic       apply_pulse,
  output logic       pending,
  output logic       mode_auto
);

  localparam int AW = $clog2(AUTO_PERIODS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, PEND, APPLY} state_t;

  state_t          state, state_nxt;
  logic [2:0]      func_sh, amp_sh, freq_sh;
  logic [2:0]      func_sh_nxt, amp_sh_nxt, freq_sh_nxt;
  logic [AW-1:0]   auto_cnt, auto_cnt_nxt;
  logic [TW-1:0]   to_cnt, to_cnt_nxt;
  logic            mode_auto_nxt;
  logic            func_hit, amp_hit, freq_hit, any_hit;
  logic            auto_step, auto_wrap;

  function automatic logic [2:0] inc_func(input logic [2:0] v);
    return (v == 3'(NUM_FUNC - 1)) ? 3'd0 : v + 3'd1;
  endfunction

  always_comb begin
    func_hit      = btn_pulse[0] & ~mode_auto;
    amp_hit       = btn_pulse[1];
    freq_hit      = btn_pulse[2];
    any_hit       = func_hit | amp_hit | freq_hit;
    auto_step     = (state == IDLE) & mode_auto & period_end;
    auto_wrap     = auto_step & (auto_cnt == AW'(AUTO_PERIODS - 1));

    state_nxt     = state;
    to_cnt_nxt    = to_cnt;
    auto_cnt_nxt  = auto_cnt;
    mode_auto_nxt = mode_auto ^ btn_pulse[3];
    // func_hit is masked in auto mode, so it can never coincide with auto_wrap
    func_sh_nxt   = (func_hit | auto_wrap) ? inc_func(func_sh) : func_sh;
    amp_sh_nxt    = amp_hit  ? amp_sh + 3'd1  : amp_sh;
    freq_sh_nxt   = freq_hit ? freq_sh + 3'd1 : freq_sh;

    case (state)
      IDLE: begin
        if (auto_wrap)
          auto_cnt_nxt = '0;
        else if (auto_step && !any_hit)
          auto_cnt_nxt = auto_cnt + 1'b1;
        if (any_hit) begin
          state_nxt  = PEND;
          to_cnt_nxt = '0;
        end else if (auto_wrap) begin
          state_nxt = APPLY;
        end
      end
      PEND: begin
        to_cnt_nxt = to_cnt + 1'b1;
        if (period_end || to_cnt == TW'(TIMEOUT - 1))
          state_nxt = APPLY;
      end
      APPLY: begin
        if (any_hit) begin
          state_nxt  = PEND;
          to_cnt_nxt = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (btn_pulse[3])
      auto_cnt_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      func_sh   <= 3'd0;
      amp_sh    <= 3'd7;
      freq_sh   <= 3'd0;
      func_sel  <= 3'd0;
      amp_sel   <= 3'd7;
      freq_sel  <= 3'd0;
      auto_cnt  <= '0;
      to_cnt    <= '0;
      mode_auto <= 1'b0;
    end else begin
      state     <= state_nxt;
      func_sh   <= func_sh_nxt;
      amp_sh    <= amp_sh_nxt;
      freq_sh   <= freq_sh_nxt;
      auto_cnt  <= auto_cnt_nxt;
      to_cnt    <= to_cnt_nxt;
      mode_auto <= mode_auto_nxt;
      // old shadow is committed; a same-cycle button update stays staged
      if (state == APPLY) begin
        func_sel <= func_sh;
        amp_sel  <= amp_sh;
        freq_sel <= freq_sh;
      end
    end
  end

  assign apply_pulse = (state == APPLY);
  assign pending     = (state != IDLE);

endmodule
